// File: rtl/capacitor_emulator_if.sv
// ---------------------------------------------------------------------------
// capacitor_emulator_if
// Streaming interface of the capacitor emulator.
//   in_valid  / in_ready  / in_i  : current-sample stream into the block
//   out_valid / out_ready / out_v : voltage-sample stream out of the block
// The slave modport is the emulator; the master modport is the environment
// that produces current samples and consumes voltage samples.
// ---------------------------------------------------------------------------
interface capacitor_emulator_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_i;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_v;

    modport master (
        output in_valid,
        output in_i,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_v
    );

    modport slave (
        input  in_valid,
        input  in_i,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_v
    );
endinterface

// File: rtl/capacitor_emulator.sv
// ---------------------------------------------------------------------------
// capacitor_emulator
// Sampled-data capacitor: integrates signed current samples into a saturating
// voltage state, v[n] = sat(v[n-1] + (i[n]*k_gain >>> SHIFT) - leak(v[n-1])).
// Ports:
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   k_gain        : unsigned gain (1/C scaled), held stable while in flight
//   clear         : synchronous clear of voltage state and sample counter
//   bus           : slave side of the current-in / voltage-out streams
//   sat_flag      : one-cycle pulse when a result was clipped
//   sample_count  : number of completed output handshakes (wraps)
// ---------------------------------------------------------------------------
module capacitor_emulator #(
    parameter int DW         = 16,
    parameter int KW         = 16,
    parameter int SHIFT      = 12,
    parameter int LEAK_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [KW-1:0]         k_gain,
    input  logic                  clear,
    capacitor_emulator_if.slave   bus,
    output logic                  sat_flag,
    output logic [15:0]           sample_count
);

    localparam int PW = DW + KW + 1;
    localparam int AW = DW + KW + 3;

    // Symmetric saturation limits; the most negative code is never produced.
    localparam logic signed [AW-1:0] VMAX = AW'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-1:0] VMIN = -VMAX;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        OUT
    } state_t;

    state_t               state_q, state_d;
    logic signed [DW-1:0] sample_q, sample_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic signed [DW-1:0] v_q, v_d;
    logic                 valid_q, valid_d;
    logic                 sat_q, sat_d;
    logic [15:0]          count_q, count_d;

    logic signed [PW-1:0] mulA;
    logic signed [PW-1:0] mulB;
    logic signed [AW-1:0] prodExt;
    logic signed [AW-1:0] vExt;
    logic signed [AW-1:0] delta;
    logic signed [AW-1:0] leak;
    logic signed [AW-1:0] sum;

    // Both multiplier operands are widened to the product width first so the
    // truncated product is the exact signed result; the gain is zero-extended.
    assign mulA    = {{(KW + 1){sample_q[DW-1]}}, sample_q};
    assign mulB    = {{DW{1'b0}}, k_gain};
    assign prodExt = {{2{prod_q[PW-1]}}, prod_q};
    assign vExt    = {{(KW + 3){v_q[DW-1]}}, v_q};
    assign delta   = prodExt >>> SHIFT;

    // A zero leakage shift means no leakage at all, not leak = v.
    if (LEAK_SHIFT != 0) begin : g_leak
        assign leak = vExt >>> LEAK_SHIFT;
    end else begin : g_noleak
        assign leak = '0;
    end

    assign sum = vExt + delta - leak;

    assign bus.in_ready  = (state_q == IDLE) & ~clear;
    assign bus.out_valid = valid_q;
    assign bus.out_v     = v_q;
    assign sat_flag      = sat_q;
    assign sample_count  = count_q;

    // State and datapath registers; everything returns to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sample_q <= '0;
            prod_q   <= '0;
            v_q      <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            prod_q   <= prod_d;
            v_q      <= v_d;
            valid_q  <= valid_d;
            sat_q    <= sat_d;
            count_q  <= count_d;
        end
    end

    // Next-state logic: capture, multiply, accumulate-and-saturate, then hold
    // the result until the consumer takes it. sat_flag defaults low so it is
    // a single-cycle pulse aligned with the rise of out_valid. clear wins
    // over everything, discarding any sample in flight.
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        prod_d   = prod_q;
        v_d      = v_q;
        valid_d  = valid_q;
        sat_d    = 1'b0;
        count_d  = count_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    sample_d = bus.in_i;
                    state_d  = MUL;
                end
            end
            MUL: begin
                prod_d  = mulA * mulB;
                state_d = ACC;
            end
            ACC: begin
                if (sum > VMAX) begin
                    v_d   = VMAX[DW-1:0];
                    sat_d = 1'b1;
                end else if (sum < VMIN) begin
                    v_d   = VMIN[DW-1:0];
                    sat_d = 1'b1;
                end else begin
                    v_d = sum[DW-1:0];
                end
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d = IDLE;
            v_d     = '0;
            valid_d = 1'b0;
            sat_d   = 1'b0;
            count_d = '0;
        end
    end

endmodule
